lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit between the execute stage and the `memdatos` data memory. Accepts one byte-addressed load or store request per transaction and converts it into word-indexed `adress`/`writedata`/`ewr`/`memread` strobes. Sub-word stores are performed by read-modify-write. Loads return sign- or zero-extended data through a valid/ready response handshake.

## Interface
- `DEPTH`, 128: number of 32-bit words in the data memory; word index must be < DEPTH.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; transfer when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: load sign-extension enable (ignored for stores and word loads).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified for sub-word sizes.
- `resp_valid` out 1: response held until accepted.
- `resp_ready` in 1: response consumed when `resp_valid & resp_ready`.
- `resp_rdata` out 32: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned, out-of-range or illegal-size request.
- `mem_adress` out 32: word index = latched `req_addr[31:2]`, zero-extended.
- `mem_writedata` out 32: merged store word.
- `mem_ewr` out 1: memory write enable.
- `mem_memread` out 1: memory read enable.
- `mem_read_data` in 32: combinational read data from memory, valid same cycle as `mem_memread`.

## Operation
- All request fields latched on acceptance; inputs ignored until next IDLE.
- Error check at acceptance: size 11; half with `addr[0]`=1; word with `addr[1:0]`≠0; `addr[31:2]` ≥ DEPTH. Error → go straight to RESP with `resp_err`=1; no memory strobe ever asserted.
- States: IDLE, READ, WRITE, RESP.
  - IDLE → READ: valid load, or byte/half store.
  - IDLE → WRITE: valid word store.
  - IDLE → RESP: error.
  - READ: `mem_memread`=1; capture `mem_read_data` into a word register. Load → RESP. Sub-word store → WRITE.
  - WRITE: `mem_ewr`=1 for exactly one cycle; `mem_writedata` = captured word with selected lane(s) replaced (word store: `req_wdata`). → RESP.
  - RESP: `resp_valid`=1; stay until `resp_ready`; then → IDLE.
- Little-endian lanes: byte lane = `addr[1:0]`, half lane = `addr[1]`.
- Load extraction: selected byte/half shifted to bit 0; bits above filled with lane MSB if `req_signed`, else 0.
- `mem_ewr`, `mem_memread` decoded only from state flops; no combinational path from any `req_*` or `resp_ready` input to any memory strobe.
- `mem_adress`, `mem_writedata` stable throughout READ and WRITE.

## Timing
- Reset (async, immediate): state IDLE; `req_ready`=1; `resp_valid`, `resp_err`, `mem_ewr`, `mem_memread`=0; `resp_rdata`, `mem_adress`, `mem_writedata`, internal registers=0.
- Reset mid-transaction abandons the request. If asserted during WRITE, `mem_ewr` drops immediately and a partial write is permitted. No response is issued.
- Cycles from acceptance edge to first `resp_valid` cycle: load 2; word store 2; sub-word store 3; error 1.
- Back-to-back: the response handshake cycle returns to IDLE; the next request is accepted no earlier than the following cycle. Throughput ≤ one transaction per 3 cycles (load/word store with `resp_ready` held high).
- `req_ready` is 0 in every non-IDLE state; a `req_valid` asserted then is not accepted and must be held.
- `resp_rdata`/`resp_err` constant while `resp_valid`=1.

## Test plan
- Reset values: hold `rst_n`=0, then release → all outputs 0 except `req_ready`=1. Pulse `rst_n` low during WRITE → `mem_ewr`=0 that same cycle, state IDLE, no `resp_valid`.
- Word store then load: store 0xDEADBEEF at addr 0x10 → one `mem_ewr` pulse, `mem_adress`=4, response after 2 cycles. Load word 0x10 → `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- Byte RMW: word 4 = 0x11223344; store byte 0xAA at addr 0x11 → READ then WRITE, `mem_writedata`=0x1122AA44. Signed byte load at 0x11 → 0xFFFFFFAA; unsigned → 0x000000AA.
- Half: store half 0x8001 at 0x12 into word 0x1122AA44 → 0x8001AA44. Signed half load at 0x12 → 0xFFFF8001.
- Errors, with no `mem_ewr`/`mem_memread` ever seen: half at 0x13, word at 0x12, size 11, word at 0x200 (index 128) → each `resp_err`=1, `resp_rdata`=0, latency 1.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load → `resp_valid` and data stable; a new `req_valid` during this time is not accepted (`req_ready`=0). It is accepted the cycle after the handshake.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Bundle of request/response handshake and data-memory strobes for the load/store unit.
// master = execute stage plus memory model; slave = lsu_ctrl.
interface lsu_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_adress;
    logic [31:0] mem_writedata;
    logic        mem_ewr;
    logic        mem_memread;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_adress, mem_writedata, mem_ewr, mem_memread
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_adress, mem_writedata, mem_ewr, mem_memread
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit: byte-addressed requests to word-indexed memory strobes, with
// read-modify-write for sub-word stores and sign/zero-extended loads.
module lsu_ctrl #(
    parameter int DEPTH = 128
) (
    input  logic      clk,
    input  logic      rst_n,
    lsu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wword_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        accept;
    logic        req_bad;

    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0: r[7:0]   = wdata[7:0];
                    2'd1: r[15:8]  = wdata[7:0];
                    2'd2: r[23:16] = wdata[7:0];
                    default: r[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Illegal size, misalignment or word index beyond the memory.
    always_comb begin
        req_bad = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr[31:2] >= 30'(DEPTH));
    end

    assign accept = bus.req_valid && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.mem_memread = 1'b0;
        bus.mem_ewr     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_bad)                                 state_nxt = RESP;
                    else if (!bus.req_we || bus.req_size != 2'b10) state_nxt = READ;
                    else                                          state_nxt = WRITE;
                end
            end
            READ: begin
                bus.mem_memread = 1'b1;
                state_nxt       = we_q ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_ewr = 1'b1;
                state_nxt   = RESP;
            end
            default: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) state_nxt = IDLE;
            end
        endcase
    end

    // Request latch on acceptance; READ captures either the merged store word or the load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            wword_q <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_bad;
        end else if (state == READ) begin
            if (we_q) wword_q <= merge_store(bus.mem_read_data, wdata_q, size_q, addr_q[1:0]);
            else      rdata_q <= extract_load(bus.mem_read_data, size_q, addr_q[1:0], sgn_q);
        end
    end

    assign bus.mem_adress    = {2'b00, addr_q[31:2]};
    assign bus.mem_writedata = wword_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Testbench for lsu_ctrl: directed vector table, hand sequences for reset and
// backpressure, and random traffic against a byte-array reference model.
module tb_lsu_ctrl;
    localparam int DEPTH = 128;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    lsu_ctrl_if ifc();

    lsu_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    // Memory model driven only by the DUT's strobes.
    logic [31:0] mem [DEPTH];
    int unsigned nwr_total = 0;
    int unsigned nrd_total = 0;
    logic [31:0] last_wadr = '0;
    logic [31:0] last_wdata = '0;

    assign ifc.mem_read_data = mem[ifc.mem_adress[AW-1:0]];

    always @(posedge clk) begin
        if (ifc.mem_ewr) begin
            mem[ifc.mem_adress[AW-1:0]] <= ifc.mem_writedata;
            nwr_total  <= nwr_total + 1;
            last_wadr  <= ifc.mem_adress;
            last_wdata <= ifc.mem_writedata;
        end
        if (ifc.mem_memread) nrd_total <= nrd_total + 1;
    end

    // Reference model: memory as a flat byte array.
    logic [7:0] ref_mem [DEPTH*4];

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [31:0] mwd;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] rdata, input logic err, input int lat,
                       input logic [31:0] mwd);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.err = err; v.lat = lat; v.mwd = mwd;
        tbl.push_back(v);
    endtask

    task automatic ref_txn(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int nwr, output int nrd);
        int nb;
        logic [31:0] v;
        nb    = 1 << size;
        err   = (size == 2'b11) || ((addr % nb) != 0) || ((addr >> 2) >= DEPTH);
        rdata = '0;
        lat   = 1;
        nwr   = 0;
        nrd   = 0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
                nwr = 1;
                nrd = (nb == 4) ? 0 : 1;
                lat = (nb == 4) ? 2 : 3;
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
                if (sgn && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
                rdata = v;
                nrd   = 1;
                lat   = 2;
            end
        end
    endtask

    task automatic run_txn(input string nm, input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                           input int hold, input logic [31:0] exp_rd, input logic exp_err,
                           input int exp_lat, input int exp_nwr, input int exp_nrd,
                           input logic chk_mwd, input logic [31:0] exp_mwd);
        int n;
        int lat;
        int unsigned wr0, rd0;
        @(negedge clk);
        ifc.req_valid  = 1'b1;
        ifc.req_we     = we;
        ifc.req_size   = size;
        ifc.req_signed = sgn;
        ifc.req_addr   = addr;
        ifc.req_wdata  = wdata;
        n = 0;
        while (!ifc.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " req_ready"}, {31'b0, ifc.req_ready}, 32'd1);
        wr0 = nwr_total;
        rd0 = nrd_total;
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        lat = 1;
        while (!ifc.resp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " rdata"}, ifc.resp_rdata, exp_rd);
        chk({nm, " err"}, {31'b0, ifc.resp_err}, {31'b0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, " hold valid"}, {31'b0, ifc.resp_valid}, 32'd1);
            chk({nm, " hold rdata"}, ifc.resp_rdata, exp_rd);
            chk({nm, " hold ready"}, {31'b0, ifc.req_ready}, 32'd0);
        end
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        ifc.resp_ready = 1'b0;
        chk({nm, " resp drop"}, {31'b0, ifc.resp_valid}, 32'd0);
        chk({nm, " ewr count"}, nwr_total - wr0, 32'(exp_nwr));
        chk({nm, " read count"}, nrd_total - rd0, 32'(exp_nrd));
        if (exp_nwr != 0) chk({nm, " wr adr"}, last_wadr, addr >> 2);
        if (chk_mwd) chk({nm, " writedata"}, last_wdata, exp_mwd);
    endtask

    task automatic chk_idle_outputs(input string nm);
        chk({nm, " req_ready"}, {31'b0, ifc.req_ready}, 32'd1);
        chk({nm, " resp_valid"}, {31'b0, ifc.resp_valid}, 32'd0);
        chk({nm, " resp_err"}, {31'b0, ifc.resp_err}, 32'd0);
        chk({nm, " resp_rdata"}, ifc.resp_rdata, 32'd0);
        chk({nm, " mem_adress"}, ifc.mem_adress, 32'd0);
        chk({nm, " mem_writedata"}, ifc.mem_writedata, 32'd0);
        chk({nm, " mem_ewr"}, {31'b0, ifc.mem_ewr}, 32'd0);
        chk({nm, " mem_memread"}, {31'b0, ifc.mem_memread}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r_rd;
        logic        r_err;
        int          r_lat, r_nwr, r_nrd;
        logic [31:0] d;

        ifc.req_valid  = 1'b0;
        ifc.req_we     = 1'b0;
        ifc.req_size   = 2'b00;
        ifc.req_signed = 1'b0;
        ifc.req_addr   = '0;
        ifc.req_wdata  = '0;
        ifc.resp_ready = 1'b0;

        // Reset values during and after reset
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("post-reset");

        // Fill every word through the DUT so both memories agree
        for (int w = 0; w < DEPTH; w++) begin
            d = $urandom;
            ref_txn(1'b1, 2'b10, 1'b0, 32'(w * 4), d, r_rd, r_err, r_lat, r_nwr, r_nrd);
            run_txn("init", 1'b1, 2'b10, 1'b0, 32'(w * 4), d, 0,
                    r_rd, r_err, r_lat, r_nwr, r_nrd, 1'b1, d);
        end

        // Reset during WRITE abandons the store
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_we = 1'b1; ifc.req_size = 2'b10;
        ifc.req_addr  = 32'h20; ifc.req_wdata = 32'h5555_AAAA;
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("midwr ewr before", {31'b0, ifc.mem_ewr}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("midwr ewr drop", {31'b0, ifc.mem_ewr}, 32'd0);
        chk("midwr req_ready", {31'b0, ifc.req_ready}, 32'd1);
        chk("midwr resp_valid", {31'b0, ifc.resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midwr no resp", {31'b0, ifc.resp_valid}, 32'd0);
        chk("midwr idle", {31'b0, ifc.req_ready}, 32'd1);

        // Directed vectors
        add(1, 2'b10, 0, 32'h10,  32'hDEAD_BEEF, 32'h0,         0, 2, 32'hDEAD_BEEF);
        add(0, 2'b10, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 0, 2, 32'h0);
        add(1, 2'b10, 0, 32'h10,  32'h1122_3344, 32'h0,         0, 2, 32'h1122_3344);
        add(1, 2'b00, 0, 32'h11,  32'h1234_56AA, 32'h0,         0, 3, 32'h1122_AA44);
        add(0, 2'b00, 1, 32'h11,  32'h0,         32'hFFFF_FFAA, 0, 2, 32'h0);
        add(0, 2'b00, 0, 32'h11,  32'h0,         32'h0000_00AA, 0, 2, 32'h0);
        add(0, 2'b10, 0, 32'h10,  32'h0,         32'h1122_AA44, 0, 2, 32'h0);
        add(1, 2'b01, 0, 32'h12,  32'h7777_8001, 32'h0,         0, 3, 32'h8001_AA44);
        add(0, 2'b01, 1, 32'h12,  32'h0,         32'hFFFF_8001, 0, 2, 32'h0);
        add(0, 2'b01, 0, 32'h12,  32'h0,         32'h0000_8001, 0, 2, 32'h0);
        add(0, 2'b10, 0, 32'h10,  32'h0,         32'h8001_AA44, 0, 2, 32'h0);
        add(1, 2'b01, 0, 32'h13,  32'h0000_1234, 32'h0,         1, 1, 32'h0);
        add(0, 2'b10, 0, 32'h12,  32'h0,         32'h0,         1, 1, 32'h0);
        add(0, 2'b11, 0, 32'h10,  32'h0,         32'h0,         1, 1, 32'h0);
        add(1, 2'b10, 0, 32'h200, 32'h1357_9BDF, 32'h0,         1, 1, 32'h0);
        add(0, 2'b00, 1, 32'h10,  32'h0,         32'h0000_0044, 0, 2, 32'h0);
        add(0, 2'b00, 0, 32'h13,  32'h0,         32'h0000_0080, 0, 2, 32'h0);
        add(0, 2'b00, 1, 32'h13,  32'h0,         32'hFFFF_FF80, 0, 2, 32'h0);
        add(1, 2'b10, 0, 32'h1FC, 32'hCAFE_F00D, 32'h0,         0, 2, 32'hCAFE_F00D);
        add(0, 2'b00, 1, 32'h1FF, 32'h0,         32'hFFFF_FFCA, 0, 2, 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            ref_txn(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                    r_rd, r_err, r_lat, r_nwr, r_nrd);
            run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].sgn,
                    tbl[i].addr, tbl[i].wdata, i % 3, tbl[i].rdata, tbl[i].err,
                    tbl[i].lat, r_nwr, r_nrd, tbl[i].we & ~tbl[i].err, tbl[i].mwd);
        end

        // Backpressure: response held 5 cycles while a new request waits
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_we = 1'b0; ifc.req_size = 2'b10;
        ifc.req_signed = 1'b0; ifc.req_addr = 32'h10;
        chk("bp accept ready", {31'b0, ifc.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        ifc.req_addr = 32'h12; ifc.req_size = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", {31'b0, ifc.resp_valid}, 32'd1);
            chk("bp rdata", ifc.resp_rdata, 32'h8001_AA44);
            chk("bp req_ready", {31'b0, ifc.req_ready}, 32'd0);
            chk("bp memread", {31'b0, ifc.mem_memread}, 32'd0);
            @(negedge clk);
        end
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        ifc.resp_ready = 1'b0;
        chk("bp idle ready", {31'b0, ifc.req_ready}, 32'd1);
        chk("bp resp gone", {31'b0, ifc.resp_valid}, 32'd0);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        chk("bp next accepted", {31'b0, ifc.mem_memread}, 32'd1);
        @(negedge clk);
        chk("bp next valid", {31'b0, ifc.resp_valid}, 32'd1);
        chk("bp next rdata", ifc.resp_rdata, 32'h0000_0001);
        ifc.resp_ready = 1'b1;
        @(negedge clk);
        ifc.resp_ready = 1'b0;

        // Random traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            logic        we, sgn;
            logic [1:0]  size;
            logic [31:0] a, wd;
            int          s;
            we  = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            s   = $urandom_range(0, 9);
            size = (s < 3) ? 2'b00 : (s < 6) ? 2'b01 : (s < 9) ? 2'b10 : 2'b11;
            a   = 32'($urandom_range(0, DEPTH * 4 + 15));
            if ($urandom_range(0, 3) != 0) begin
                if (size == 2'b01) a[0] = 1'b0;
                if (size == 2'b10) a[1:0] = 2'b00;
            end
            wd = $urandom;
            ref_txn(we, size, sgn, a, wd, r_rd, r_err, r_lat, r_nwr, r_nrd);
            run_txn("rand", we, size, sgn, a, wd, $urandom_range(0, 3),
                    r_rd, r_err, r_lat, r_nwr, r_nrd, 1'b0, 32'h0);
        end

        // Final memory contents against the byte-level model
        @(negedge clk);
        for (int w = 0; w < DEPTH; w++)
            chk($sformatf("mem word %0d", w), mem[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
